serial_uart_bridge: RTL
=======================

Name: serial_uart_bridge

Overview:
Peripheral end of the processor's byte-serial console interface. It accepts bytes the core writes to the serial port and transmits them as 8N1 UART frames. It also receives UART frames and presents them to the core through a show-ahead RX FIFO. It sits at board top level between the processor's serial_* ports and the DE1-SoC UART pins.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
FIFO_AW, 3, log2 of depth of each FIFO (TX and RX depth = 2**FIFO_AW = 8).

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
tx_data_in  input  8  byte from core (connects to processor serial_out)
tx_wren_in  input  1  push tx_data_in into TX FIFO, one byte per high cycle
tx_ready_out  output  1  TX FIFO not full (to serial_ready_in)
rx_data_out  output  8  RX FIFO head byte, show-ahead (to serial_in)
rx_valid_out  output  1  RX FIFO not empty (to serial_valid_in)
rx_rden_in  input  1  pop RX FIFO head (from serial_rden_out)
uart_txd  output  1  UART transmit line, idle high
uart_rxd  input  1  UART receive line, asynchronous
tx_busy_out  output  1  TX engine not IDLE or TX FIFO non-empty
rx_overrun_out  output  1  sticky: received byte dropped because RX FIFO was full
frame_err_out  output  1  sticky: stop bit sampled low

Behaviour:
- Reset values: uart_txd=1, tx_ready_out=1, rx_valid_out=0, rx_data_out=8'h00, tx_busy_out=0, both sticky flags 0. Both FIFOs are emptied; both FSMs go to IDLE. Reset mid-frame aborts the frame immediately, and uart_txd returns high asynchronously.
- FIFOs: circular, FIFO_AW-bit pointers, (FIFO_AW+1)-bit count. Status outputs derive from registered count.
- A push is accepted if count<depth, or if a pop occurs in the same cycle; otherwise it is dropped.
- A pop when empty is ignored. Simultaneous push+pop on an empty FIFO: the push is accepted and the pop is ignored.
- TX FSM has states IDLE, START, DATA, STOP.
  - IDLE: if the TX FIFO is non-empty, pop the head into the shift register and go to START.
  - START: uart_txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: uart_txd=1 for CLKS_PER_BIT cycles, then IDLE.
- TX latency and spacing: wren in cycle N into an empty idle bridge gives uart_txd falling at cycle N+2. Back-to-back frames are separated by exactly 1 idle-high cycle.
- RX input: uart_rxd passes through a 2-flop synchronizer, reset value 1.
- RX FSM has states IDLE, START, DATA, STOP.
  - IDLE: a synchronized falling edge goes to START.
  - START: at CLKS_PER_BIT/2 cycles, if the line is still 0 go to DATA; else return to IDLE (glitch, no flag).
  - DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
  - STOP: sample once at CLKS_PER_BIT after the last data bit. If 1, push the byte (dropped and rx_overrun set if the push is refused). If 0, discard the byte and set frame_err. Either way return to IDLE.
- RX latency: rx_valid_out rises the cycle after the stop-bit sample.
- rx_data_out always equals the FIFO head. It updates the cycle after a pop, and is undefined-but-stable (last value) when empty.
- Sticky flags clear only on reset.
- RX and TX are fully independent; full-duplex operation is required.

Test Plan:
- CLKS_PER_BIT=8. Reset, then wren 0x55 once -> uart_txd low at +2 cycles, then bits 1,0,1,0,1,0,1,0 each 8 cycles, stop high 8 cycles; tx_busy_out falls after the stop bit.
- Push 9 bytes 0x00..0x08 in consecutive cycles while the TX engine is stalled in a frame -> tx_ready_out=0 after the 8th accepted byte. Whether the 9th byte is accepted depends on a same-cycle pop; check the transmitted byte sequence matches the accepted bytes exactly, with 1-cycle frame gaps.
- Drive 0xA3 frame on uart_rxd -> rx_valid_out=1 with rx_data_out=0xA3. Pulse rx_rden_in -> rx_valid_out=0 next cycle.
- Send 9 RX frames with no reads -> 8 bytes held in order, rx_overrun_out=1 after the 9th. A 3-cycle low glitch on uart_rxd produces no byte.
- Frame 0x3C with stop bit 0 -> no FIFO push, frame_err_out=1. Assert reset mid-TX-frame -> uart_txd=1 immediately, FIFOs empty, flags 0.
- Full-duplex: loop uart_txd to uart_rxd, push 0x48,0x69 -> both bytes read back in order, no errors.

Source files
------------

// File: rtl/serial_uart_bridge.sv
// 8N1 UART bridge between the core's byte-serial console port and the board pins.
// Each direction has its own circular FIFO; TX and RX run fully independently.
module serial_uart_bridge #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_AW = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data_in,
   input  logic       tx_wren_in,
   output logic       tx_ready_out,
   output logic [7:0] rx_data_out,
   output logic       rx_valid_out,
   input  logic       rx_rden_in,
   output logic       uart_txd,
   input  logic       uart_rxd,
   output logic       tx_busy_out,
   output logic       rx_overrun_out,
   output logic       frame_err_out
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int NW = FIFO_AW + 1;
   localparam logic [NW-1:0] FULL = NW'(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t tx_state, tx_next, rx_state, rx_next;

   logic [7:0]         tx_mem [DEPTH];
   logic [FIFO_AW-1:0] tx_wp, tx_rp;
   logic [NW-1:0]      tx_cnt;
   logic               tx_push, tx_pop, tx_tick;
   logic [CW-1:0]      tx_clk;
   logic [2:0]         tx_bit;
   logic [7:0]         tx_shift;

   logic [7:0]         rx_mem [DEPTH];
   logic [FIFO_AW-1:0] rx_wp, rx_rp;
   logic [NW-1:0]      rx_cnt;
   logic               rx_push, rx_pop, rx_tick, rx_half;
   logic               rx_push_req, rx_bad_stop;
   logic [CW-1:0]      rx_clk;
   logic [2:0]         rx_bit;
   logic [7:0]         rx_shift;
   logic               rx_meta, rx_sync, rx_prev;

   // ---------------- TX FIFO ----------------
   assign tx_pop = (tx_state == IDLE) && (tx_cnt != '0);
   assign tx_push = tx_wren_in && ((tx_cnt != FULL) || tx_pop);
   assign tx_ready_out = (tx_cnt != FULL);
   assign tx_busy_out = (tx_state != IDLE) || (tx_cnt != '0);

   always_ff @(posedge clock) begin
      if (tx_push) tx_mem[tx_wp] <= tx_data_in;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_wp <= '0;
         tx_rp <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + FIFO_AW'(1);
         if (tx_pop) tx_rp <= tx_rp + FIFO_AW'(1);
         tx_cnt <= tx_cnt + NW'(tx_push) - NW'(tx_pop);
      end
   end

   // ---------------- TX engine ----------------
   assign tx_tick = (tx_clk == LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) tx_state <= IDLE;
      else tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         IDLE:  if (tx_cnt != '0) tx_next = START;
         START: if (tx_tick) tx_next = DATA;
         DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = STOP;
         STOP:  if (tx_tick) tx_next = IDLE;
         default: tx_next = IDLE;
      endcase
   end

   // Line is decoded from the state register so reset forces it high at once
   always_comb begin
      uart_txd = 1'b1;
      unique case (tx_state)
         START: uart_txd = 1'b0;
         DATA:  uart_txd = tx_shift[0];
         default: uart_txd = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_clk <= '0;
         tx_bit <= '0;
         tx_shift <= '0;
      end else if (tx_state == IDLE) begin
         tx_clk <= '0;
         tx_bit <= '0;
         if (tx_pop) tx_shift <= tx_mem[tx_rp];
      end else if (tx_tick) begin
         tx_clk <= '0;
         if (tx_state == DATA) begin
            tx_shift <= tx_shift >> 1;
            tx_bit <= tx_bit + 3'd1;
         end
      end else begin
         tx_clk <= tx_clk + CW'(1);
      end
   end

   // ---------------- RX engine ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= uart_rxd;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign rx_tick = (rx_clk == LAST);
   assign rx_half = (rx_clk == HALF);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) rx_state <= IDLE;
      else rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      unique case (rx_state)
         IDLE:  if (rx_prev && !rx_sync) rx_next = START;
         START: if (rx_half) rx_next = rx_sync ? IDLE : DATA;
         DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = STOP;
         STOP:  if (rx_tick) rx_next = IDLE;
         default: rx_next = IDLE;
      endcase
   end

   always_comb begin
      rx_push_req = 1'b0;
      rx_bad_stop = 1'b0;
      if (rx_state == STOP && rx_tick) begin
         rx_push_req = rx_sync;
         rx_bad_stop = !rx_sync;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_clk <= '0;
         rx_bit <= '0;
         rx_shift <= '0;
      end else begin
         unique case (rx_state)
            IDLE: begin
               rx_clk <= '0;
               rx_bit <= '0;
            end
            START: rx_clk <= rx_half ? '0 : rx_clk + CW'(1);
            DATA: begin
               if (rx_tick) begin
                  rx_clk <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  rx_bit <= rx_bit + 3'd1;
               end else begin
                  rx_clk <= rx_clk + CW'(1);
               end
            end
            default: rx_clk <= rx_clk + CW'(1);
         endcase
      end
   end

   // ---------------- RX FIFO and status ----------------
   assign rx_pop = rx_rden_in && (rx_cnt != '0);
   assign rx_push = rx_push_req && ((rx_cnt != FULL) || rx_pop);
   assign rx_valid_out = (rx_cnt != '0);
   assign rx_data_out = rx_mem[rx_rp];

   // Storage is cleared so the show-ahead head reads zero out of reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) rx_mem[i] <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
         rx_cnt <= '0;
         rx_overrun_out <= 1'b0;
         frame_err_out <= 1'b0;
      end else begin
         if (rx_push) begin
            rx_mem[rx_wp] <= rx_shift;
            rx_wp <= rx_wp + FIFO_AW'(1);
         end
         if (rx_pop) rx_rp <= rx_rp + FIFO_AW'(1);
         rx_cnt <= rx_cnt + NW'(rx_push) - NW'(rx_pop);
         if (rx_push_req && !rx_push) rx_overrun_out <= 1'b1;
         if (rx_bad_stop) frame_err_out <= 1'b1;
      end
   end

endmodule
